// File: rtl/mux_mon_pkg.sv
// Shared types, defaults and the reference mux function for the mux settle monitor.
package mux_mon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2,
      REPORT = 2'd3
   } mon_state_e;

   localparam int DEF_STABLE  = 2;
   localparam int DEF_TIMEOUT = 127;

   // Value both mux outputs should settle to for a given {a,b,s,e}.
   function automatic logic mux_exp(input logic a, input logic b, input logic s, input logic e);
      logic r;
      if (e) begin
         if (s) r = b;
         else   r = a;
      end else begin
         r = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/vec_change_det.sv
// Registers a stimulus vector and flags any cycle where the live vector differs from it.
module vec_change_det #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] vec_in,
   output logic         chg
);

   logic [W-1:0] vec_q;
   logic [W-1:0] vec_d;

   // Next registered vector is always the live one.
   always_comb begin
      vec_d = vec_in;
   end

   // Vector register.
   always_ff @(posedge clk) begin
      if (rst) vec_q <= {W{1'b0}};
      else     vec_q <= vec_d;
   end

   assign chg = (vec_in != vec_q);

endmodule

// File: rtl/mux_settle_monitor.sv
// Measures how long both mux outputs take to settle after each stimulus change.
// Define MUX_SETTLE_GLITCH_EN to count HOLD->SETTLE glitches per event on glitch_cnt.
module mux_settle_monitor
   import mux_mon_pkg::*;
#(
   parameter int CNT_W         = 8,
   parameter int STABLE_CYCLES = DEF_STABLE,
   parameter int TIMEOUT       = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       vec_in,
   input  logic             out_e,
   input  logic             out_buf,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] settle_cnt,
   output logic [CNT_W-1:0] max_settle,
   output logic             mismatch,
   output logic             timeout,
   output logic [CNT_W-1:0] event_cnt,
   output logic [CNT_W-1:0] glitch_cnt
);

   localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [3:0]       STABLE_C = 4'(STABLE_CYCLES);

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       hold_q, hold_d;
   logic [CNT_W-1:0] first_q, first_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic             mis_q, mis_d;
   logic             to_q, to_d;
   logic [CNT_W-1:0] evt_q, evt_d;
`ifdef MUX_SETTLE_GLITCH_EN
   logic [CNT_W-1:0] grun_q, grun_d;
   logic [CNT_W-1:0] glitch_q, glitch_d;
`endif

   logic             chg_s;
   logic             exp_s;
   logic             match_s;
   logic             mis_now_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [3:0]       hold_inc_s;
   logic [CNT_W-1:0] first_s;

   vec_change_det #(.W(4)) u_chg (
      .clk    (clk),
      .rst    (rst),
      .vec_in (vec_in),
      .chg    (chg_s)
   );

   // With e=0 the buffer mux output is floating, so only out_e is judged.
   assign exp_s      = mux_exp(vec_in[3], vec_in[2], vec_in[1], vec_in[0]);
   assign match_s    = vec_in[0] ? ((out_e == exp_s) && (out_buf == exp_s)) : (out_e == exp_s);
   assign mis_now_s  = vec_in[0] & (out_e ^ out_buf);
   assign cnt_inc_s  = (cnt_q >= TO_C) ? TO_C : (cnt_q + ONE_C);
   assign hold_inc_s = hold_q + 4'd1;
   assign first_s    = (hold_q == 4'd0) ? cnt_inc_s : first_q;

   // Next-state and published-result logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      first_d  = first_q;
      done_d   = 1'b0;
      settle_d = settle_q;
      max_d    = max_q;
      mis_d    = mis_q;
      to_d     = to_q;
      evt_d    = evt_q;
`ifdef MUX_SETTLE_GLITCH_EN
      grun_d   = grun_q;
      glitch_d = glitch_q;
`endif
      case (state_q)
         IDLE, REPORT: begin
            if (chg_s) begin
               state_d = SETTLE;
               cnt_d   = {CNT_W{1'b0}};
               hold_d  = 4'd0;
`ifdef MUX_SETTLE_GLITCH_EN
               grun_d  = {CNT_W{1'b0}};
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE, HOLD: begin
            if (chg_s) begin
               state_d = SETTLE;
               cnt_d   = {CNT_W{1'b0}};
               hold_d  = 4'd0;
`ifdef MUX_SETTLE_GLITCH_EN
               grun_d  = {CNT_W{1'b0}};
`endif
            end else if (match_s && (hold_inc_s == STABLE_C)) begin
               state_d  = REPORT;
               done_d   = 1'b1;
               settle_d = first_s;
               to_d     = 1'b0;
               mis_d    = mis_now_s;
               evt_d    = evt_q + ONE_C;
               if (first_s > max_q) max_d = first_s;
               else                 max_d = max_q;
`ifdef MUX_SETTLE_GLITCH_EN
               glitch_d = grun_q;
`endif
            end else if (cnt_inc_s == TO_C) begin
               state_d  = REPORT;
               done_d   = 1'b1;
               settle_d = TO_C;
               to_d     = 1'b1;
               mis_d    = mis_now_s;
               evt_d    = evt_q + ONE_C;
`ifdef MUX_SETTLE_GLITCH_EN
               glitch_d = grun_q;
`endif
            end else if (match_s) begin
               state_d = HOLD;
               cnt_d   = cnt_inc_s;
               hold_d  = hold_inc_s;
               first_d = first_s;
            end else begin
               state_d = SETTLE;
               cnt_d   = cnt_inc_s;
               hold_d  = 4'd0;
`ifdef MUX_SETTLE_GLITCH_EN
               if ((state_q == HOLD) && (grun_q != {CNT_W{1'b1}})) grun_d = grun_q + ONE_C;
               else                                                grun_d = grun_q;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == SETTLE) || (state_d == HOLD);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         hold_q   <= 4'd0;
         first_q  <= {CNT_W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         settle_q <= {CNT_W{1'b0}};
         max_q    <= {CNT_W{1'b0}};
         mis_q    <= 1'b0;
         to_q     <= 1'b0;
         evt_q    <= {CNT_W{1'b0}};
`ifdef MUX_SETTLE_GLITCH_EN
         grun_q   <= {CNT_W{1'b0}};
         glitch_q <= {CNT_W{1'b0}};
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         first_q  <= first_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         settle_q <= settle_d;
         max_q    <= max_d;
         mis_q    <= mis_d;
         to_q     <= to_d;
         evt_q    <= evt_d;
`ifdef MUX_SETTLE_GLITCH_EN
         grun_q   <= grun_d;
         glitch_q <= glitch_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign settle_cnt = settle_q;
   assign max_settle = max_q;
   assign mismatch   = mis_q;
   assign timeout    = to_q;
   assign event_cnt  = evt_q;
`ifdef MUX_SETTLE_GLITCH_EN
   assign glitch_cnt = glitch_q;
`else
   assign glitch_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mux_settle_monitor.sv
// Randomised bench: records a full stimulus/response trace, then predicts every output from an event-level model.
module tb_mux_settle_monitor;

   localparam int NMAX      = 4000;
   localparam int STABLE_P  = 2;
   localparam int TIMEOUT_P = 127;
   localparam int K_END = 0, K_RESET = 1, K_RESTART = 2, K_DONE = 3, K_TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] vec_in = 4'b0000;
   logic       out_e = 1'b0;
   logic       out_buf = 1'b0;
   logic       busy, done, mismatch, timeout;
   logic [7:0] settle_cnt, max_settle, event_cnt, glitch_cnt;

   mux_settle_monitor dut (
      .clk(clk), .rst(rst), .vec_in(vec_in), .out_e(out_e), .out_buf(out_buf),
      .busy(busy), .done(done), .settle_cnt(settle_cnt), .max_settle(max_settle),
      .mismatch(mismatch), .timeout(timeout), .event_cnt(event_cnt), .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   // stimulus trace
   logic [3:0] tv [NMAX];
   logic       toe [NMAX];
   logic       tob [NMAX];
   logic       tr [NMAX];
   // observed outputs
   logic       d_busy [NMAX];
   logic       d_done [NMAX];
   logic       d_mis [NMAX];
   logic       d_to [NMAX];
   logic [7:0] d_settle [NMAX];
   logic [7:0] d_max [NMAX];
   logic [7:0] d_evt [NMAX];
   logic [7:0] d_gl [NMAX];
   // predicted outputs
   int e_busy [NMAX], e_done [NMAX], e_mis [NMAX], e_to [NMAX];
   int e_settle [NMAX], e_max [NMAX], e_evt [NMAX], e_gl [NMAX];

   int cyc = 0;
   int ncyc = 0;
   int n_total = 0;
   int n_bad = 0;
   int p_settle = 0, p_max = 0, p_mis = 0, p_to = 0, p_evt = 0, p_gl = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step(input logic [3:0] v, input logic oe, input logic ob, input logic r);
      vec_in = v; out_e = oe; out_buf = ob; rst = r;
      tv[cyc] = v; toe[cyc] = oe; tob[cyc] = ob; tr[cyc] = r;
      @(negedge clk);
      d_busy[cyc] = busy;  d_done[cyc] = done;  d_mis[cyc] = mismatch; d_to[cyc] = timeout;
      d_settle[cyc] = settle_cnt; d_max[cyc] = max_settle; d_evt[cyc] = event_cnt; d_gl[cyc] = glitch_cnt;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic ref_exp(input logic [3:0] v);
      // v = {a,b,s,e}
      if (v[0] == 1'b0) return 1'b0;
      return v[1] ? v[2] : v[3];
   endfunction

   function automatic bit chg_at(input int c);
      logic [3:0] prev;
      prev = tr[c-1] ? 4'b0000 : tv[c-1];
      return tv[c] != prev;
   endfunction

   function automatic bit match_at(input int c);
      logic x;
      x = ref_exp(tv[c]);
      if (tv[c][0]) return (toe[c] == x) && (tob[c] == x);
      return toe[c] == x;
   endfunction

   task automatic put(input int c, input int b, input int dn);
      e_busy[c] = b; e_done[c] = dn; e_mis[c] = p_mis; e_to[c] = p_to;
      e_settle[c] = p_settle; e_max[c] = p_max; e_evt[c] = p_evt; e_gl[c] = p_gl;
   endtask

   // Follow one measurement from its start cycle to whatever ends it.
   task automatic resolve(input int t0, output int x, output int kind, output int st, output int gl);
      int run, rs, y;
      bit m;
      run = 0; rs = 0; gl = 0; st = 0; kind = K_END; x = ncyc - 1;
      for (int j = 1; j <= TIMEOUT_P; j++) begin
         y = t0 + j;
         if (y >= ncyc) return;
         if (tr[y]) begin x = y; kind = K_RESET; return; end
         if (chg_at(y)) begin x = y; kind = K_RESTART; return; end
         m = match_at(y);
         if (m) begin
            if (run == 0) rs = j;
            run++;
            if (run == STABLE_P) begin x = y; kind = K_DONE; st = rs; return; end
         end
         if (j == TIMEOUT_P) begin x = y; kind = K_TO; st = TIMEOUT_P; return; end
         if (!m) begin
            if (run > 0 && gl < 255) gl++;
            run = 0;
         end
      end
   endtask

   task automatic build_expect();
      int c, t0, x, kind, st, gl;
      int rep;
      c = 1; rep = 0;
      while (c < ncyc) begin
         put(c, 0, rep);
         rep = 0;
         if (tr[c]) begin
            p_settle = 0; p_max = 0; p_mis = 0; p_to = 0; p_evt = 0; p_gl = 0;
            c++;
         end else if (!chg_at(c)) begin
            c++;
         end else begin
            t0 = c;
            forever begin
               resolve(t0, x, kind, st, gl);
               for (int k = t0 + 1; k <= x; k++) put(k, 1, 0);
               if (kind != K_RESTART) break;
               t0 = x;
            end
            if (kind == K_RESET) begin
               p_settle = 0; p_max = 0; p_mis = 0; p_to = 0; p_evt = 0; p_gl = 0;
               c = x + 1;
            end else if (kind == K_DONE || kind == K_TO) begin
               p_settle = st;
               p_to = (kind == K_TO) ? 1 : 0;
               p_mis = (tv[x][0] && (toe[x] != tob[x])) ? 1 : 0;
               p_evt = (p_evt + 1) % 256;
               if (kind == K_DONE && st > p_max) p_max = st;
`ifdef MUX_SETTLE_GLITCH_EN
               p_gl = gl;
`else
               p_gl = 0;
`endif
               c = x + 1;
               rep = 1;
            end else begin
               c = ncyc;
            end
         end
      end
   endtask

   initial begin
      int s1, s2, s3, s4, s5, s6;
      int len, de, db, rst_at;
      bit to_mode;
      logic [3:0] v;
      logic ex, oe, ob;

      @(posedge clk);
      #1;
      step(4'b0000, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) step(4'b0000, 1'b0, 1'b0, 1'b0);
      s1 = cyc;
      for (int k = 0; k < 8; k++) step(4'b1111, 1'b1, 1'b1, 1'b0);
      s2 = cyc;
      for (int k = 0; k < 12; k++) step(4'b1101, k >= 3, k >= 3, 1'b0);
      s3 = cyc;
      for (int k = 0; k < 12; k++) step(4'b1011, 1'b0, (k < 4) || (k == 5), 1'b0);
      s4 = cyc;
      for (int k = 0; k < 8; k++) step(4'b1000, 1'b0, 1'b1, 1'b0);
      s5 = cyc;
      for (int k = 0; k < 135; k++) step(4'b1001, 1'b0, 1'b1, 1'b0);
      s6 = cyc;
      for (int k = 0; k < 3; k++) step(4'b0101, 1'b1, 1'b1, 1'b0);
      step(4'b0111, 1'b1, 1'b1, 1'b0);
      step(4'b0111, 1'b1, 1'b1, 1'b0);
      step(4'b0111, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) step(4'b0111, 1'b1, 1'b1, 1'b0);

      while (cyc < NMAX - 160) begin
         v = 4'($urandom_range(0, 15));
         to_mode = ($urandom_range(0, 9) == 0);
         len = to_mode ? 135 : int'($urandom_range(1, 30));
         de = $urandom_range(0, 5);
         db = $urandom_range(0, 5);
         rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         ex = ref_exp(v);
         for (int k = 0; k < len; k++) begin
            if (to_mode) oe = ~ex;
            else if (k >= de) oe = ($urandom_range(0, 19) == 0) ? ~ex : ex;
            else oe = 1'($urandom_range(0, 1));
            ob = (k >= db && v[0]) ? ex : 1'($urandom_range(0, 1));
            step(v, oe, ob, k == rst_at);
         end
      end
      ncyc = cyc;

      build_expect();
      for (int c = 1; c < ncyc; c++) begin
         check_val($sformatf("busy@%0d", c), 32'(d_busy[c]), e_busy[c]);
         check_val($sformatf("done@%0d", c), 32'(d_done[c]), e_done[c]);
         check_val($sformatf("settle@%0d", c), 32'(d_settle[c]), e_settle[c]);
         check_val($sformatf("max@%0d", c), 32'(d_max[c]), e_max[c]);
         check_val($sformatf("mismatch@%0d", c), 32'(d_mis[c]), e_mis[c]);
         check_val($sformatf("timeout@%0d", c), 32'(d_to[c]), e_to[c]);
         check_val($sformatf("event_cnt@%0d", c), 32'(d_evt[c]), e_evt[c]);
         check_val($sformatf("glitch@%0d", c), 32'(d_gl[c]), e_gl[c]);
      end

      // hand-derived spot checks on the directed scenarios
      check_val("rst_evt", 32'(d_evt[1]), 0);
      check_val("idle_busy", 32'(d_busy[s1 - 1]), 0);
      check_val("zero_delay_settle", 32'(d_settle[s1 + 3]), 1);
      check_val("hold_no_done", 32'(d_done[s1 + 6]), 0);
      check_val("s2_early", 32'(d_done[s2 + 4]), 0);
      check_val("s2_done", 32'(d_done[s2 + 5]), 1);
      check_val("s2_settle", 32'(d_settle[s2 + 5]), 3);
      check_val("s2_max", 32'(d_max[s2 + 5]), 3);
      check_val("s2_to", 32'(d_to[s2 + 5]), 0);
      check_val("s3_done", 32'(d_done[s3 + 8]), 1);
      check_val("s3_settle", 32'(d_settle[s3 + 8]), 6);
`ifdef MUX_SETTLE_GLITCH_EN
      check_val("s3_glitch", 32'(d_gl[s3 + 8]), 1);
`else
      check_val("s3_glitch", 32'(d_gl[s3 + 8]), 0);
`endif
      check_val("s4_done", 32'(d_done[s4 + 3]), 1);
      check_val("s4_settle", 32'(d_settle[s4 + 3]), 1);
      check_val("s4_mis", 32'(d_mis[s4 + 3]), 0);
      check_val("s5_done", 32'(d_done[s5 + 128]), 1);
      check_val("s5_settle", 32'(d_settle[s5 + 128]), 127);
      check_val("s5_to", 32'(d_to[s5 + 128]), 1);
      check_val("s5_mis", 32'(d_mis[s5 + 128]), 1);
      check_val("s5_max", 32'(d_max[s5 + 128]), 6);
      check_val("s5_evt", 32'(d_evt[s5 + 128]), 5);
      for (int k = 0; k <= 6; k++) check_val($sformatf("s6_done+%0d", k), 32'(d_done[s6 + k]), 0);
      check_val("s6_busy_hold", 32'(d_busy[s6 + 5]), 1);
      check_val("s6_rst_evt", 32'(d_evt[s6 + 6]), 0);
      check_val("s6_rst_max", 32'(d_max[s6 + 6]), 0);
      check_val("s6_rst_settle", 32'(d_settle[s6 + 6]), 0);
      check_val("s6_rst_busy", 32'(d_busy[s6 + 6]), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
